regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised general-purpose register file with read-port forwarding and a busy-bit scoreboard.
//  Serves as the pipelined CPU's register stage.
//  - Decode reads two operands and marks a destination busy at issue.
//  - Writeback clears the busy bit.
//  - Byte enables allow partial writes.
//  - A flattened dump bus feeds the debug display.
// PARAMETERS
//  WIDTH     32  data word width in bits, multiple of 8
//  NREGS     8   number of registers, power of 2, >= 2
//  AW        $clog2(NREGS)  address width (derived, not overridden)
//  ZERO_REG  0   1: reg 0 reads 0, ignores writes, is never busy
//  BYPASS    1   1: same-cycle write data is forwarded to the read ports
// PORTS
//  clk       in   1              clock, rising edge
//  n_rst     in   1              asynchronous active-low reset
//  ra1       in   AW             read address, port 1
//  ra2       in   AW             read address, port 2
//  rd1       out  WIDTH          read data, port 1 (combinational)
//  rd2       out  WIDTH          read data, port 2 (combinational)
//  rd1_busy  out  1              busy bit of ra1 (combinational)
//  rd2_busy  out  1              busy bit of ra2 (combinational)
//  we        in   1              write (writeback) enable
//  wa        in   AW             write address
//  wd        in   WIDTH          write data
//  wbe       in   WIDTH/8        byte enables; bit i covers wd[8i+7:8i]
//  iss       in   1              issue strobe: mark ia busy
//  ia        in   AW             issue (destination) address
//  busy_cnt  out  AW+1           number of busy registers (registered)
//  rf_flat   out  NREGS*WIDTH    register r at bits [r*WIDTH +: WIDTH] (registered)
// BEHAVIOUR
//  Reset (n_rst=0, async):
//  - All registers, busy bits and busy_cnt go to 0; rf_flat=0.
//  - rd*/rd*_busy reflect the cleared state.
//  - Reset mid-write discards the write.
//  Write, at posedge clk when we=1:
//  - For each i with wbe[i]=1, rf[wa] byte i <= wd byte i; other bytes hold.
//  - we=1 with wbe=0 leaves the data unchanged but still clears busy[wa].
//  Read: rdN = rf[raN], zero latency.
//  - If BYPASS=1 && we && wa==raN: enabled bytes come from wd, the remaining bytes from rf[raN].
//  - If BYPASS=0: new data is visible the cycle after the write edge.
//  Scoreboard, at each posedge:
//  - iss=1 sets busy[ia].
//  - we=1 clears busy[wa].
//  - iss && we && ia==wa: busy stays SET (the new producer wins).
//  - iss on an already-busy register: stays set, no count change.
//  - rdN_busy = busy[raN] from the registered state only; the same-cycle clear is NOT forwarded.
//  busy_cnt: updated on the same edge as the busy bits; delta = (#set 0->1) - (#cleared 1->0), range 0..NREGS.
//  ZERO_REG=1: rd*=0 and rd*_busy=0 when ra*=0; writes and issues to 0 are ignored; rf_flat[0 +: WIDTH]=0.
//  Addresses are always in range (NREGS is a power of 2); no wrap handling is needed.
//  No X on any output after reset for any input sequence.
// STRUCTURE
//  Package regfile_pkg:
//  - default WIDTH/NREGS constants;
//  - bytes-per-word constant WIDTH/8;
//  - function byte_merge(old,new,be).
//  Sub-module regfile_rd_port: address select + bypass/zero-reg merge + busy lookup.
//  - Instantiated twice (ports 1 and 2).
//  Top holds the storage array, busy vector, busy_cnt counter and rf_flat pack.
// TESTING
//  1 Reset: write 0xDEADBEEF to r3, pulse n_rst low mid-cycle -> rd1(ra1=3)=0, busy_cnt=0, rf_flat=0.
//  2 Byte write: r2=0x11223344, then we, wbe=4'b0101, wd=0xAABBCCDD
//    -> r2=0x11BB33DD; same cycle with ra1=2 and BYPASS=1 -> rd1=0x11BB33DD.
//  3 Scoreboard: iss ia=5 -> next cycle rd2_busy(ra2=5)=1, busy_cnt=1; we wa=5 -> busy=0, busy_cnt=0.
//  4 Collision: r4 busy; iss ia=4 and we wa=4 same edge -> busy[4]=1, busy_cnt unchanged, r4 updated.
//  5 Dual events: iss ia=1 and we wa=6 (r6 busy) same edge -> busy_cnt unchanged, busy[1]=1, busy[6]=0.
//  6 ZERO_REG=1: we wa=0 wd=0xFFFFFFFF, iss ia=0 -> rd1(ra1=0)=0, rd1_busy=0, busy_cnt=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and the byte-merge helper for the register file and its read ports.
package regfile_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_NREGS      = 8;
  localparam int BYTES_PER_WORD = DEF_WIDTH / 8;

  // The helper works on a fixed wide word so it can serve any WIDTH up to this size.
  localparam int MERGE_MAX_W    = 1024;
  localparam int MERGE_MAX_BE   = MERGE_MAX_W / 8;

  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]  old_w,
    input logic [MERGE_MAX_W-1:0]  new_w,
    input logic [MERGE_MAX_BE-1:0] be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MERGE_MAX_BE; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: register select, optional write bypass, zero-register
// masking and busy-bit lookup.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int  WIDTH    = DEF_WIDTH,
  parameter int  NREGS    = DEF_NREGS,
  parameter int  ZERO_REG = 0,
  parameter int  BYPASS   = 1,
  localparam int AW       = $clog2(NREGS),
  localparam int BE_W     = WIDTH / 8
) (
  input  logic [AW-1:0]    i_ra,
  input  logic [WIDTH-1:0] i_rf [NREGS],
  input  logic [NREGS-1:0] i_busy,
  input  logic             i_we,
  input  logic [AW-1:0]    i_wa,
  input  logic [WIDTH-1:0] i_wd,
  input  logic [BE_W-1:0]  i_wbe,
  output logic [WIDTH-1:0] o_rd,
  output logic             o_busy
);

  // Busy is looked up from registered state only; a same-cycle clear is not forwarded.
  always_comb begin
    o_rd   = i_rf[i_ra];
    o_busy = i_busy[i_ra];
    if (BYPASS != 0 && i_we && (i_wa == i_ra)) begin
      o_rd = WIDTH'(byte_merge(MERGE_MAX_W'(i_rf[i_ra]), MERGE_MAX_W'(i_wd),
                               MERGE_MAX_BE'(i_wbe)));
    end
    if (ZERO_REG != 0 && i_ra == '0) begin
      o_rd   = '0;
      o_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with byte-enabled writeback, two forwarding read ports, a busy-bit
// scoreboard with population count, and a flattened dump of all registers.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  WIDTH    = DEF_WIDTH,
  parameter int  NREGS    = DEF_NREGS,
  parameter int  ZERO_REG = 0,
  parameter int  BYPASS   = 1,
  localparam int AW       = $clog2(NREGS),
  localparam int BE_W     = WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [AW-1:0]          ra1,
  input  logic [AW-1:0]          ra2,
  output logic [WIDTH-1:0]       rd1,
  output logic [WIDTH-1:0]       rd2,
  output logic                   rd1_busy,
  output logic                   rd2_busy,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic [BE_W-1:0]        wbe,
  input  logic                   iss,
  input  logic [AW-1:0]          ia,
  output logic [AW:0]            busy_cnt,
  output logic [NREGS*WIDTH-1:0] rf_flat
);

  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_rf [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [CW-1:0]    r_busy_cnt;
  logic [NREGS-1:0] w_busy_nxt;
  logic [CW-1:0]    w_busy_cnt_nxt;
  logic             w_wr_ok;

  assign w_wr_ok = we && !(ZERO_REG != 0 && wa == '0);

  // Clear first, then set, so a producer issued on the writeback edge keeps the bit.
  always_comb begin
    w_busy_nxt = r_busy;
    if (we)  w_busy_nxt[wa] = 1'b0;
    if (iss) w_busy_nxt[ia] = 1'b1;
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
    w_busy_cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_busy_cnt_nxt = w_busy_cnt_nxt + CW'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (w_wr_ok) begin
      r_rf[wa] <= WIDTH'(byte_merge(MERGE_MAX_W'(r_rf[wa]), MERGE_MAX_W'(wd),
                                    MERGE_MAX_BE'(wbe)));
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
    end
  end

  assign busy_cnt = r_busy_cnt;

  always_comb begin
    rf_flat = '0;
    for (int r = 0; r < NREGS; r++) begin
      rf_flat[r*WIDTH +: WIDTH] = r_rf[r];
    end
    if (ZERO_REG != 0) rf_flat[0 +: WIDTH] = '0;
  end

  regfile_rd_port #(
    .WIDTH    (WIDTH),
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_rd_port1 (
    .i_ra   (ra1),
    .i_rf   (r_rf),
    .i_busy (r_busy),
    .i_we   (we),
    .i_wa   (wa),
    .i_wd   (wd),
    .i_wbe  (wbe),
    .o_rd   (rd1),
    .o_busy (rd1_busy)
  );

  regfile_rd_port #(
    .WIDTH    (WIDTH),
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_rd_port2 (
    .i_ra   (ra2),
    .i_rf   (r_rf),
    .i_busy (r_busy),
    .i_we   (we),
    .i_wa   (wa),
    .i_wd   (wd),
    .i_wbe  (wbe),
    .o_rd   (rd2),
    .o_busy (rd2_busy)
  );

endmodule
